// File: rtl/rx_iq_nibble_streamer.sv
// Purpose : drains 48-bit IQ words from a show-ahead FIFO in fixed-size bursts and serializes
//           each word MSB-first as 4-bit nibbles toward the Raspberry Pi RX interface.
// Latency : the first nibble appears on pi_rx_data one clk after the arm cycle.
//           A burst lasts NIB*BURST cycles.
// Backpr. : none from the Pi side. The FIFO is popped only on arm/reload cycles.
//           A pop never happens while the FIFO is empty; an empty FIFO streams zeros and sets a
//           sticky underflow flag instead.
// Ports   : clk/rst_n       - Pi RX clock, async active-low reset
//           run             - streaming enable
//           fifo_q/_empty/_usedw - show-ahead FIFO head, empty flag, fill count
//           fifo_rdreq      - combinational pop strobe
//           pi_rx_samples/pi_rx_data - burst-active flag and nibble (both registered)
//           underflow       - sticky, cleared by reset or run=0
module rx_iq_nibble_streamer #(
  parameter int IQ_W    = 24,
  parameter int BURST   = 8,
  parameter int USEDW_W = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [2*IQ_W-1:0]    fifo_q,
  input  logic                 fifo_empty,
  input  logic [USEDW_W-1:0]   fifo_usedw,
  output logic                 fifo_rdreq,
  output logic                 pi_rx_samples,
  output logic [3:0]           pi_rx_data,
  output logic                 underflow
);

  localparam int W     = 2 * IQ_W;
  localparam int NIB   = W / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [NIB_W-1:0]   NIB_LAST = NIB_W'(NIB - 1);
  localparam logic [USEDW_W-1:0] BURST_V  = USEDW_W'(BURST);

  logic [0:0]         state_q, state_d;
  logic [W-1:0]       sr_q, sr_d;
  logic [NIB_W-1:0]   nib_q, nib_d;
  logic [USEDW_W-1:0] cnt_q, cnt_d;
  logic               samples_q, samples_d;
  logic               underflow_q, underflow_d;
  logic               load;   // a new word is due this cycle (arm or reload)
  logic               take;   // the word is actually popped from the FIFO

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    nib_d       = nib_q;
    cnt_d       = cnt_q;
    samples_d   = samples_q;
    underflow_d = underflow_q;
    load        = 1'b0;
    take        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run && (fifo_usedw >= BURST_V)) begin
          load      = 1'b1;
          nib_d     = '0;
          cnt_d     = BURST_V - USEDW_W'(1);
          samples_d = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      default: begin
        if (!run) begin
          // Abort: the partial word is dropped and the data lines are forced quiet.
          state_d   = ST_IDLE;
          sr_d      = '0;
          nib_d     = '0;
          cnt_d     = '0;
          samples_d = 1'b0;
        end else if (nib_q != NIB_LAST) begin
          sr_d  = sr_q << 4;
          nib_d = nib_q + NIB_W'(1);
        end else if (cnt_q != '0) begin
          load  = 1'b1;
          nib_d = '0;
          cnt_d = cnt_q - USEDW_W'(1);
        end else begin
          // Clearing sr here keeps pi_rx_data at zero for the whole IDLE period.
          state_d   = ST_IDLE;
          sr_d      = '0;
          nib_d     = '0;
          samples_d = 1'b0;
        end
      end
    endcase

    // An empty FIFO on a load keeps burst timing intact but streams a zero word.
    if (load) begin
      if (fifo_empty) begin
        sr_d        = '0;
        underflow_d = 1'b1;
      end else begin
        take = 1'b1;
        sr_d = fifo_q;
      end
    end

    if (!run) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      nib_q       <= '0;
      cnt_q       <= '0;
      samples_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      nib_q       <= nib_d;
      cnt_q       <= cnt_d;
      samples_q   <= samples_d;
      underflow_q <= underflow_d;
    end
  end

  // The arm decision is combinational, so it is masked while reset is held.
  // Without the mask, a pop could fire during reset.
  assign fifo_rdreq    = take & rst_n;
  assign pi_rx_samples = samples_q;
  assign pi_rx_data    = sr_q[W-1 -: 4];
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_rx_iq_nibble_streamer.sv
module tb_rx_iq_nibble_streamer;

  localparam int IQ_W    = 24;
  localparam int BURST   = 8;
  localparam int USEDW_W = 11;
  localparam int NIB     = 2 * IQ_W / 4;
  localparam int BLEN    = NIB * BURST;

  typedef logic [2*IQ_W-1:0] word_t;
  typedef word_t             wq_t[$];

  typedef struct {
    logic               run;
    logic [USEDW_W-1:0] usedw;
    logic               empty;
    word_t              head;
    logic               exp_rd;
    logic               exp_s;
    logic [3:0]         exp_d;
    logic               exp_u;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               run;
  word_t              tb_q;
  logic               tb_empty;
  logic [USEDW_W-1:0] tb_usedw;
  logic               fifo_rdreq;
  logic               pi_rx_samples;
  logic [3:0]         pi_rx_data;
  logic               underflow;

  rx_iq_nibble_streamer #(.IQ_W(IQ_W), .BURST(BURST), .USEDW_W(USEDW_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .fifo_q        (tb_q),
    .fifo_empty    (tb_empty),
    .fifo_usedw    (tb_usedw),
    .fifo_rdreq    (fifo_rdreq),
    .pi_rx_samples (pi_rx_samples),
    .pi_rx_data    (pi_rx_data),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    viol   = 0;
  logic  force_empty = 1'b0;
  wq_t   fifo_m;
  wq_t   popped;
  logic  tr_rd[$];
  logic  tr_s[$];
  logic  tr_u[$];
  logic [3:0] tr_d[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t rnd_word();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic sync_fifo();
    tb_q     = (fifo_m.size() > 0) ? fifo_m[0] : '0;
    tb_empty = force_empty || (fifo_m.size() == 0);
    tb_usedw = USEDW_W'(fifo_m.size());
  endtask

  task automatic clear_trace();
    tr_rd.delete(); tr_s.delete(); tr_d.delete(); tr_u.delete();
  endtask

  // One clock cycle: the task starts at a negedge, inputs are already set, and pops occur at the posedge.
  task automatic tick();
    logic rd_now;
    sync_fifo();
    #1;
    rd_now = fifo_rdreq;
    if (rd_now && tb_empty) viol++;
    @(posedge clk);
    if (rd_now && fifo_m.size() > 0) popped.push_back(fifo_m.pop_front());
    @(negedge clk);
    tr_rd.push_back(rd_now);
    tr_s.push_back(pi_rx_samples);
    tr_d.push_back(pi_rx_data);
    tr_u.push_back(underflow);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    force_empty = 1'b0;
    fifo_m.delete();
    popped.delete();
    clear_trace();
    sync_fifo();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model for the stream when run is held high from trace cycle 0.
  // Burst b arms at cycle b*(BLEN+1) and streams words e[b*BURST ..] for BLEN cycles.
  task automatic check_stream(input string tag, input wq_t e, input int skip_rd, input logic exp_no_uf);
    int nb, bad_s, bad_d, bad_r, bad_u, hi;
    nb = e.size() / BURST;
    bad_s = 0; bad_d = 0; bad_r = 0; bad_u = 0; hi = 0;
    for (int c = 0; c < tr_s.size(); c++) begin
      logic es, er;
      logic [3:0] ed;
      word_t tmp;
      es = 1'b0; er = 1'b0; ed = 4'h0;
      for (int b = 0; b < nb; b++) begin
        int off;
        off = c - b * (BLEN + 1);
        if (off >= 0 && off < BLEN) begin
          es  = 1'b1;
          tmp = e[b * BURST + off / NIB] >> (4 * (NIB - 1 - off % NIB));
          ed  = tmp[3:0];
          if (off % NIB == 0 && c != skip_rd) er = 1'b1;
        end
      end
      if (tr_s[c] !== es) bad_s++;
      if (tr_d[c] !== ed) bad_d++;
      if (tr_rd[c] !== er) bad_r++;
      if (exp_no_uf && tr_u[c] !== 1'b0) bad_u++;
      if (tr_s[c] === 1'b1) hi++;
    end
    chk({tag, "_samples_mism"}, 64'(bad_s), 64'd0);
    chk({tag, "_data_mism"}, 64'(bad_d), 64'd0);
    chk({tag, "_rdreq_mism"}, 64'(bad_r), 64'd0);
    chk({tag, "_samples_hi_cycles"}, 64'(hi), 64'(nb * BLEN));
    if (exp_no_uf) chk({tag, "_underflow_mism"}, 64'(bad_u), 64'd0);
  endtask

  task automatic check_pops(input string tag, input wq_t e);
    int bad;
    bad = 0;
    chk({tag, "_pop_count"}, 64'(popped.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < popped.size(); i++)
      if (popped[i] !== e[i]) bad++;
    chk({tag, "_pop_order_mism"}, 64'(bad), 64'd0);
  endtask

  vec_t vecs[8];
  wq_t  w, e;
  logic [3:0] seq[12];

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    sync_fifo();

    // ---- Table-driven arm decision from IDLE (one edge per vector) ----
    vecs[0] = '{1'b0, 11'd100,  1'b0, 48'hA00000_000001, 1'b0, 1'b0, 4'h0, 1'b0};
    vecs[1] = '{1'b1, 11'd7,    1'b0, 48'hB00000_000002, 1'b0, 1'b0, 4'h0, 1'b0};
    vecs[2] = '{1'b1, 11'd8,    1'b0, 48'hC00000_000003, 1'b1, 1'b1, 4'hC, 1'b0};
    vecs[3] = '{1'b1, 11'd2047, 1'b0, 48'h700000_000004, 1'b1, 1'b1, 4'h7, 1'b0};
    vecs[4] = '{1'b1, 11'd0,    1'b0, 48'hD00000_000005, 1'b0, 1'b0, 4'h0, 1'b0};
    vecs[5] = '{1'b1, 11'd8,    1'b1, 48'hE00000_000006, 1'b0, 1'b1, 4'h0, 1'b1};
    vecs[6] = '{1'b0, 11'd8,    1'b1, 48'hF00000_000007, 1'b0, 1'b0, 4'h0, 1'b0};
    vecs[7] = '{1'b1, 11'd9,    1'b0, 48'h900000_000008, 1'b1, 1'b1, 4'h9, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      tb_q = vecs[i].head; tb_empty = vecs[i].empty; tb_usedw = vecs[i].usedw; run = vecs[i].run;
      #1;
      chk($sformatf("tbl%0d_rdreq", i), 64'(fifo_rdreq), 64'(vecs[i].exp_rd));
      @(posedge clk); @(negedge clk);
      chk($sformatf("tbl%0d_samples", i), 64'(pi_rx_samples), 64'(vecs[i].exp_s));
      chk($sformatf("tbl%0d_data", i), 64'(pi_rx_data), 64'(vecs[i].exp_d));
      chk($sformatf("tbl%0d_underflow", i), 64'(underflow), 64'(vecs[i].exp_u));
      run = 1'b0;
    end

    // ---- Reset with FIFO preloaded, then 20 idle cycles with run=0 ----
    rst_n = 1'b0; run = 1'b1;
    fifo_m.delete(); popped.delete();
    for (int i = 0; i < 8; i++) fifo_m.push_back(rnd_word());
    sync_fifo(); #1;
    chk("rst_rdreq", 64'(fifo_rdreq), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("rst_samples", 64'(pi_rx_samples), 64'd0);
    chk("rst_data", 64'(pi_rx_data), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    run = 1'b0; rst_n = 1'b1;
    clear_trace();
    repeat (20) tick();
    begin
      int n; n = 0;
      foreach (tr_rd[i]) if (tr_rd[i]) n++;
      chk("idle_run0_rdreq_pulses", 64'(n), 64'd0);
    end

    // ---- Single burst with a known first word ----
    do_reset();
    w.delete();
    w.push_back(48'h123456_ABCDEF);
    for (int i = 1; i < 8; i++) w.push_back(rnd_word());
    fifo_m = w;
    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    run = 1'b1;
    repeat (100) tick();
    chk("b1_rdreq_on_arm", 64'(tr_rd[0]), 64'd1);
    begin
      int bad, n, last, badsp; bad = 0; n = 0; last = -12; badsp = 0;
      for (int i = 0; i < 12; i++) if (tr_d[i] !== seq[i]) bad++;
      chk("b1_first_word_nibbles", 64'(bad), 64'd0);
      foreach (tr_rd[i]) if (tr_rd[i]) begin
        if (i - last != 12) badsp++;
        last = i; n++;
      end
      chk("b1_rdreq_pulses", 64'(n), 64'd8);
      chk("b1_rdreq_spacing_bad", 64'(badsp), 64'd0);
    end
    check_stream("b1", w, -1, 1'b1);
    check_pops("b1", w);

    // ---- usedw threshold: 7 words never arm, the 8th arms the same cycle ----
    do_reset();
    w.delete();
    for (int i = 0; i < 7; i++) w.push_back(rnd_word());
    fifo_m = w;
    run = 1'b1;
    repeat (10) tick();
    begin
      int n; n = 0;
      foreach (tr_rd[i]) if (tr_rd[i] || tr_s[i]) n++;
      chk("usedw7_no_arm", 64'(n), 64'd0);
    end
    fifo_m.push_back(rnd_word());
    tick();
    chk("usedw8_arm_same_cycle", 64'(tr_rd[10]), 64'd1);
    chk("usedw8_samples", 64'(tr_s[10]), 64'd1);
    chk("usedw8_first_nibble", 64'(tr_d[10]), 64'(w[0][47:44]));

    // ---- Two back-to-back bursts ----
    do_reset();
    w.delete();
    for (int i = 0; i < 16; i++) w.push_back(rnd_word());
    fifo_m = w;
    run = 1'b1;
    repeat (200) tick();
    chk("b2_gap_before", 64'(tr_s[95]), 64'd1);
    chk("b2_gap_low", 64'(tr_s[96]), 64'd0);
    chk("b2_gap_after", 64'(tr_s[97]), 64'd1);
    check_stream("b2", w, -1, 1'b1);
    check_pops("b2", w);

    // ---- Underflow at the 3rd reload (trace cycle 36) ----
    do_reset();
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back(rnd_word());
    fifo_m = w;
    run = 1'b1;
    for (int c = 0; c < 100; c++) begin
      force_empty = (c == 36);
      tick();
    end
    force_empty = 1'b0;
    e.delete();
    for (int i = 0; i < 3; i++) e.push_back(w[i]);
    e.push_back('0);
    for (int i = 3; i < 7; i++) e.push_back(w[i]);
    check_stream("uf", e, 36, 1'b0);
    chk("uf_before", 64'(tr_u[35]), 64'd0);
    chk("uf_set", 64'(tr_u[36]), 64'd1);
    chk("uf_sticky", 64'(tr_u[99]), 64'd1);
    e.delete();
    for (int i = 0; i < 7; i++) e.push_back(w[i]);
    check_pops("uf", e);
    run = 1'b0;
    tick();
    chk("uf_cleared_by_run0", 64'(underflow), 64'd0);

    // ---- run dropped while nibble 5 of word 2 is on the bus ----
    do_reset();
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back(rnd_word());
    fifo_m = w;
    run = 1'b1;
    repeat (30) tick();
    chk("drop_nibble5_shown", 64'(tr_d[29]), 64'(w[2][27:24]));
    run = 1'b0;
    repeat (6) tick();
    chk("drop_samples", 64'(tr_s[30]), 64'd0);
    chk("drop_data", 64'(tr_d[30]), 64'd0);
    begin
      int n; n = 0;
      for (int i = 30; i < 36; i++) if (tr_rd[i]) n++;
      chk("drop_no_rdreq", 64'(n), 64'd0);
    end
    e.delete();
    for (int i = 0; i < 3; i++) e.push_back(w[i]);
    check_pops("drop", e);
    for (int i = 0; i < 3; i++) begin
      word_t x; x = rnd_word(); w.push_back(x); fifo_m.push_back(x);
    end
    clear_trace();
    run = 1'b1;
    tick();
    chk("rearm_rdreq", 64'(tr_rd[0]), 64'd1);
    chk("rearm_first_nibble", 64'(tr_d[0]), 64'(w[3][47:44]));

    // ---- Randomized streams against the reference model ----
    for (int it = 0; it < 4; it++) begin
      int n, nb, pre;
      do_reset();
      n = $urandom_range(8, 30);
      pre = $urandom_range(0, 5);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back(rnd_word());
      fifo_m = w;
      repeat (pre) tick();
      begin
        int k; k = 0;
        foreach (tr_rd[i]) if (tr_rd[i]) k++;
        chk($sformatf("rnd%0d_pre_idle_rdreq", it), 64'(k), 64'd0);
      end
      clear_trace();
      run = 1'b1;
      nb = n / BURST;
      repeat (nb * (BLEN + 1) + 8) tick();
      e.delete();
      for (int i = 0; i < nb * BURST; i++) e.push_back(w[i]);
      check_stream($sformatf("rnd%0d", it), e, -1, 1'b1);
      check_pops($sformatf("rnd%0d", it), e);
    end

    chk("rdreq_while_empty", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
